// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall controller for the 5-stage MIPS core.
// Drives the latch enables and flushes for IF/ID, ID/EX, EX/MEM, MEM/WB and the PC.
// A small FSM tracks the data-memory wait and the drain that follows a halt.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_dREN,
  input  logic       mem_dREN,
  input  logic       mem_dWEN,
  input  logic       mem_pcsrc,
  input  logic       mem_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic       halt
);

  // Drain counter must hold DRAIN_CYCLES; keep at least one bit when it is 0.
  localparam int unsigned DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t         r_state;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_halt;

  logic w_dmiss;
  logic w_load_use;
  logic w_branch_flush;

  assign w_dmiss    = (mem_dREN | mem_dWEN) & ~dhit;
  // $zero is hardwired, so a load targeting it can never feed a dependent instruction.
  assign w_load_use = ex_dREN & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  // Branch flush only happens in RUN when no halt or data miss outranks it and fetch is done.
  assign w_branch_flush = (r_state == RUN) & ~mem_halt & ~w_dmiss & mem_pcsrc & ihit;

  assign halt = r_halt;

  // Latch enables and flushes decoded from the current state and this cycle's hazards.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_halt) begin
          // Squash everything younger than the halt; let MEM/WB retire.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
        end else if (w_dmiss) begin
          // Freeze the whole pipe while memory is busy.
        end else if (mem_pcsrc) begin
          if (ihit) begin
            pc_en       = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
          end
        end else if (w_load_use && ihit) begin
          // Hold PC and IF/ID, bubble into EX, let the load advance.
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end else begin
          pc_en    = ihit;
          ifid_en  = ihit;
          idex_en  = ihit;
          exmem_en = ihit;
          memwb_en = ihit;
        end
      end
      DWAIT: begin
        // Hazard checks are skipped in the release cycle; the front end only needs ihit.
        if (dhit) begin
          pc_en    = ihit;
          ifid_en  = ihit;
          idex_en  = ihit;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
      DRAIN: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
      end
      default: begin
        // HALTED: everything frozen until reset.
      end
    endcase
  end

  // Controller FSM: data-miss wait, halt drain and the sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_halt      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (mem_halt) begin
            if (DRAIN_CYCLES == 0) begin
              r_state <= HALTED;
              r_halt  <= 1'b1;
            end else begin
              r_state     <= DRAIN;
              r_drain_cnt <= DCW'(DRAIN_CYCLES);
            end
          end else if (w_dmiss) begin
            r_state <= DWAIT;
          end
        end
        DWAIT: begin
          if (dhit) begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          if (r_drain_cnt <= DCW'(1)) begin
            r_state     <= HALTED;
            r_halt      <= 1'b1;
            r_drain_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt - DCW'(1);
          end
        end
        default: begin
          r_state <= HALTED;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;

  assign w_stall_inc = ((r_state == RUN) | (r_state == DWAIT)) & ~pc_en;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  // Saturating perf counters; they stop naturally once HALTED since neither term fires there.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_branch_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = w_branch_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (DRAIN_CYCLES = 2).
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_dREN, mem_dREN, mem_dWEN, mem_pcsrc, mem_halt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, halt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Expected vector layout: {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, halt}
  localparam logic [8:0] ALL0 = 9'b0_0000_000_0;
  localparam logic [8:0] NORM = 9'b1_1111_000_0;
  localparam logic [8:0] LU   = 9'b0_0011_010_0;
  localparam logic [8:0] BR   = 9'b1_0001_111_0;
  localparam logic [8:0] DRN  = 9'b0_0001_111_0;
  localparam logic [8:0] HLT  = 9'b0_0000_000_1;

  hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .ex_dREN(ex_dREN),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_pcsrc(mem_pcsrc), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compare outputs; a latch enable is don't-care where its flush is expected.
  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs, mask;
    #2;
    obs  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt};
    mask = 9'h1FF;
    mask[7] = ~exp[3];
    mask[6] = ~exp[2];
    mask[5] = ~exp[1];
    n_checks++;
    assert ((obs & mask) === (exp & mask)) begin
      n_pass++;
      $display("check %s obs=%b exp=%b ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s obs=%0d exp=%0d ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask
`endif

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_dREN = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_pcsrc = 1'b0; mem_halt = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    ihit = 1'b0;
    chk("reset_idle", ALL0);
`ifdef HAZARD_PERF_EN
    chk_cnt("reset_stall_cnt", stall_cnt, 32'd0);
    chk_cnt("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    tick();
    nRST = 1'b1;
    tick();

    // Normal flow
    idle_inputs();
    id_rs = 5'd3; id_rt = 5'd4; ex_rt = 5'd9;
    chk("normal", NORM);
    ihit = 1'b0;
    chk("normal_no_ihit", ALL0);
    tick();

    // Load-use on rs, then dependency gone
    idle_inputs();
    ex_dREN = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd6;
    chk("load_use_rs", LU);
    tick();
    ex_dREN = 1'b0;
    chk("after_load_use", NORM);
    tick();

    // Load into $zero never stalls
    ex_dREN = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    chk("load_use_r0", NORM);
    tick();

    // Load-use on rt
    ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
    chk("load_use_rt", LU);
    tick();

    // Data miss: 3 frozen cycles (RUN detect + 2 in DWAIT), then release
    idle_inputs();
    mem_dREN = 1'b1; dhit = 1'b0;
    chk("dmiss_run", ALL0);
    tick();
    chk("dwait_1", ALL0);
    tick();
    chk("dwait_2", ALL0);
    tick();
    dhit = 1'b1;
    ex_dREN = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;   // ignored in the release cycle
    chk("dwait_dhit", NORM);
    tick();
    idle_inputs();
    chk("after_dwait", NORM);
    tick();

    // Store that hits is not a miss
    mem_dWEN = 1'b1; dhit = 1'b1;
    chk("store_hit", NORM);
    tick();

    // Branch outranks load-use; without ihit it holds
    idle_inputs();
    mem_pcsrc = 1'b1; ex_dREN = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    ihit = 1'b0;
    chk("branch_no_ihit", ALL0);
    tick();
    ihit = 1'b1;
    chk("branch_over_lu", BR);
    tick();
`ifdef HAZARD_PERF_EN
    chk_cnt("flush_cnt_one", flush_cnt, 32'd1);
`endif

    // Halt together with a data miss: halt wins, then drain 2 cycles
    idle_inputs();
    mem_halt = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
    chk("halt_over_dmiss", DRN);
    tick();
    idle_inputs();
    chk("drain_1", DRN);
    tick();
    chk("drain_2", DRN);
    tick();
    chk("halted", HLT);
    mem_pcsrc = 1'b1; mem_dREN = 1'b1; ex_dREN = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    tick();
    chk("halted_toggle_1", HLT);
    idle_inputs();
    mem_halt = 1'b1; ihit = 1'b0;
    tick();
    chk("halted_toggle_2", HLT);

    // Asynchronous reset out of HALTED
    idle_inputs();
    nRST = 1'b0;
    chk("reset_clears_halt", NORM);
    tick();
    nRST = 1'b1;
    tick();
    chk("run_after_reset", NORM);
    tick();

    // Asynchronous reset while in DWAIT
    mem_dREN = 1'b1; dhit = 1'b0;
    tick();
    chk("dwait_again", ALL0);
    #2;
    nRST = 1'b0;
    mem_dREN = 1'b0;
    chk("reset_in_dwait", NORM);
    tick();
    nRST = 1'b1;
    tick();
    chk("run_after_dwait_reset", NORM);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
